// File: rtl/fmul_pipe_param.sv
// IEEE-754 binary32 multiplier with STAGES-deep pipeline, valid/ready flow control and a sideband tag.
// Define FMUL_PIPE_FLAGS_EN to add the registered flags[3:0] = {invalid, overflow, underflow, inexact} port.

package fmul_pipe_param_pkg;

   typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

   // After unpacking: operand class, raw exponent sum and two 24x12 partial products.
   typedef struct packed {
      logic        sign;
      cls_e        cls;
      logic [9:0]  exp;
      logic [35:0] pp_lo;
      logic [35:0] pp_hi;
   } pp_t;

   typedef struct packed {
      logic        sign;
      cls_e        cls;
      logic [9:0]  exp;
      logic [47:0] prod;
   } prod_t;

   typedef struct packed {
      logic [31:0] c;
`ifdef FMUL_PIPE_FLAGS_EN
      logic [3:0]  flags;
`endif
   } res_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   function automatic pp_t pp_calc(input logic [31:0] a, input logic [31:0] b);
      pp_t        p;
      logic       za, zb, ia, ib, na, nb;
      logic [23:0] ma, mb;
      // Subnormal operands fall into the zero class.
      za = (a[30:23] == 8'd0);
      zb = (b[30:23] == 8'd0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      p.sign = a[31] ^ b[31];
      if (na || nb || (ia && zb) || (ib && za)) p.cls = CLS_NAN;
      else if (ia || ib)                        p.cls = CLS_INF;
      else if (za || zb)                        p.cls = CLS_ZERO;
      else                                      p.cls = CLS_NUM;
      p.exp   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      ma      = {1'b1, a[22:0]};
      mb      = {1'b1, b[22:0]};
      p.pp_lo = 36'(ma) * 36'(mb[11:0]);
      p.pp_hi = 36'(ma) * 36'(mb[23:12]);
      return p;
   endfunction

   function automatic prod_t sum_pp(input pp_t p);
      prod_t s;
      s.sign = p.sign;
      s.cls  = p.cls;
      s.exp  = p.exp;
      s.prod = {12'd0, p.pp_lo} + {p.pp_hi, 12'd0};
      return s;
   endfunction

   function automatic res_t round_pack(input prod_t p);
      res_t        r;
      logic [22:0] frac;
      logic        g, rb, st, up;
      logic [24:0] rnd;
      logic [9:0]  e;
      // NOTE: defaulting every output first keeps this logic purely combinational (no latches) wherever it is used.
      r = '0;
      if (p.prod[47]) begin
         frac = p.prod[46:24];
         g    = p.prod[23];
         rb   = p.prod[22];
         st   = |p.prod[21:0];
         e    = p.exp + 10'd1;
      end else begin
         frac = p.prod[45:23];
         g    = p.prod[22];
         rb   = p.prod[21];
         st   = |p.prod[20:0];
         e    = p.exp;
      end
      up  = g & (rb | st | frac[0]);
      rnd = {2'b01, frac} + {24'd0, up};
      if (rnd[24]) e = e + 10'd1;
      case (p.cls)
         CLS_NAN: begin
            r.c = QNAN;
`ifdef FMUL_PIPE_FLAGS_EN
            r.flags = 4'b1000;
`endif
         end
         CLS_INF:  r.c = {p.sign, 8'hFF, 23'd0};
         CLS_ZERO: r.c = {p.sign, 31'd0};
         default: begin
            if ($signed(e) <= 10'sd0) begin
               r.c = {p.sign, 31'd0};
`ifdef FMUL_PIPE_FLAGS_EN
               r.flags = 4'b0011;
`endif
            end else if ($signed(e) >= 10'sd255) begin
               r.c = {p.sign, 8'hFF, 23'd0};
`ifdef FMUL_PIPE_FLAGS_EN
               r.flags = 4'b0101;
`endif
            end else begin
               r.c = {p.sign, e[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
`ifdef FMUL_PIPE_FLAGS_EN
               r.flags = {3'b000, g | rb | st};
`endif
            end
         end
      endcase
      return r;
   endfunction

endpackage

module fmul_pipe_param
   import fmul_pipe_param_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      c,
   output logic [TAG_W-1:0] out_tag
`ifdef FMUL_PIPE_FLAGS_EN
   ,
   output logic [3:0]       flags
`endif
);

   // Multiply, sum and round each get their own register once there are enough stages.
   localparam int FIRST_RES = (STAGES >= 3) ? 2 : STAGES - 1;
   localparam int NRES      = STAGES - FIRST_RES;

   logic             advance;
   logic [STAGES-1:0] vld_q;
   logic [TAG_W-1:0] tag_q [STAGES];
   pp_t              pp_c;
   res_t             res_d;
   res_t             res_q [NRES];

   assign advance = !out_valid || out_ready;
   assign in_ready = advance;
   assign pp_c     = pp_calc(a, b);

   // NOTE: every pipeline register, data included, is reset so c and out_tag read zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
      end else if (advance) begin
         // NOTE: non-blocking updates let every stage sample its predecessor's old value in one pass.
         vld_q[0] <= in_valid;
         tag_q[0] <= in_tag;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   if (STAGES == 1) begin : g_front1
      assign res_d = round_pack(sum_pp(pp_c));
   end else if (STAGES == 2) begin : g_front2
      prod_t prod_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)         prod_q <= '0;
         else if (advance) prod_q <= sum_pp(pp_c);
      end
      assign res_d = round_pack(prod_q);
   end else begin : g_front3
      pp_t   pp_q;
      prod_t prod_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            pp_q   <= '0;
            prod_q <= '0;
         end else if (advance) begin
            pp_q   <= pp_c;
            prod_q <= sum_pp(pp_q);
         end
      end
      assign res_d = round_pack(prod_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NRES; i++) res_q[i] <= '0;
      end else if (advance) begin
         res_q[0] <= res_d;
         for (int i = 1; i < NRES; i++) res_q[i] <= res_q[i-1];
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign c         = res_q[NRES-1].c;
   assign out_tag   = tag_q[STAGES-1];
`ifdef FMUL_PIPE_FLAGS_EN
   assign flags     = res_q[NRES-1].flags;
`endif

endmodule

// File: tb/tb_fmul_pipe_param.sv
// Self-checking bench for fmul_pipe_param: exact-integer binary32 reference model, scoreboard and directed corners.
// Flag checks are compiled in when FMUL_PIPE_FLAGS_EN is defined.

module tb_fmul_pipe_param;

   localparam int STAGES = 3;
   localparam int TAG_W  = 5;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      a;
   logic [31:0]      b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      c;
   logic [TAG_W-1:0] out_tag;
`ifdef FMUL_PIPE_FLAGS_EN
   logic [3:0]       flags;
`endif

   fmul_pipe_param #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .out_tag   (out_tag)
`ifdef FMUL_PIPE_FLAGS_EN
      ,
      .flags     (flags)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns {invalid, overflow, underflow, inexact, c} from the real-number definition of the product.
   function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, k, sh, e;
      logic s, xz, yz, xi, yi, xn, yn;
      longint unsigned p, q, rem, half;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s  = x[31] ^ y[31];
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC00000};
      if (xi || yi) return {4'b0000, s, 8'hFF, 23'd0};
      if (xz || yz) return {4'b0000, s, 31'd0};
      p = (64'(x[22:0]) | 64'h80_0000) * (64'(y[22:0]) | 64'h80_0000);
      k = 47;
      while (k > 0 && !p[k]) k--;
      sh   = k - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         k++;
      end
      e = ex + ey - 127 + (k - 46);
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0011, s, 31'd0};
      return {3'b000, rem != 0, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 9))
         0:       return $urandom;
         1:       return {1'($urandom), 8'd0, 23'($urandom)};
         2:       return {1'($urandom), 8'hFF, ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
         3:       return {1'($urandom), 8'($urandom_range(1, 20)), 23'($urandom)};
         4:       return {1'($urandom), 8'($urandom_range(230, 254)), 23'($urandom)};
         default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      endcase
   endfunction

   typedef struct {
      logic [31:0]      c;
      logic [TAG_W-1:0] tag;
      logic [3:0]       flags;
   } exp_t;

   exp_t             exp_q[$];
   logic             stall_prev = 1'b0;
   logic [31:0]      prev_c;
   logic [TAG_W-1:0] prev_tag;

   // Scoreboard: transfers are decided by the values settled at the falling edge.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [35:0] m;
      if (!rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         check("in_ready_eq_advance", in_ready, !out_valid || out_ready);
         if (stall_prev) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_c", c, prev_c);
            check("stall_hold_tag", out_tag, prev_tag);
         end
         if (out_valid && out_ready) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("stream_c", c, e.c);
               check("stream_tag", out_tag, e.tag);
`ifdef FMUL_PIPE_FLAGS_EN
               check("stream_flags", flags, e.flags);
`endif
            end
         end
         if (in_valid && in_ready) begin
            m       = ref_mul(a, b);
            e.c     = m[31:0];
            e.flags = m[35:32];
            e.tag   = in_tag;
            exp_q.push_back(e);
         end
         stall_prev = out_valid && !out_ready;
         prev_c     = c;
         prev_tag   = out_tag;
      end
   end

   // One op with out_ready held high; checks the literal result and the exact latency.
   task automatic send_one(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [TAG_W-1:0] t, input logic [31:0] exp_c);
      int   lat;
      logic seen;
      lat       = 0;
      seen      = 1'b0;
      out_ready = 1'b1;
      a         = x;
      b         = y;
      in_tag    = t;
      in_valid  = 1'b1;
      @(negedge clk);
      check({name, "_accept"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      while (lat < 20 && !seen) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
      end
      check({name, "_latency"}, lat, STAGES);
      check({name, "_c"}, c, exp_c);
      check({name, "_tag"}, out_tag, t);
      @(posedge clk);
      #1;
   endtask

   task automatic run_stream(input int n, input logic patterned);
      int         sent;
      int         k;
      logic [3:0] pat;
      sent = 0;
      k    = 0;
      pat  = 4'b1001;
      while ((sent < n || exp_q.size() != 0) && k < 4000) begin
         out_ready = patterned ? pat[k % 4] : ($urandom_range(0, 3) != 0);
         if (sent < n && (patterned || $urandom_range(0, 4) != 0)) begin
            in_valid = 1'b1;
            a        = rand_op();
            b        = rand_op();
            in_tag   = patterned ? TAG_W'(sent) : TAG_W'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
         k++;
      end
      check("stream_drained", (sent == n) && (exp_q.size() == 0), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic reset_mid_flight();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = rand_op();
         b        = rand_op();
         in_tag   = TAG_W'(i + 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_c", c, 0);
      check("midrst_tag", out_tag, 0);
      repeat (2) @(posedge clk);
      #1;
      check("midrst_c_held", c, 0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_reset_idle", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send_one("post_reset", 32'h3FC00000, 32'h40000000, 5'd9, 32'h40400000);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      #12;
      check("reset_out_valid", out_valid, 0);
      check("reset_c", c, 0);
      check("reset_out_tag", out_tag, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Hand-computed values that pin the reference model.
      check("model_basic",   ref_mul(32'h3FC00000, 32'h40000000), {4'b0000, 32'h40400000});
      check("model_tie_up",  ref_mul(32'h3F800001, 32'h3FC00000), {4'b0001, 32'h3FC00002});
      check("model_tie_dn",  ref_mul(32'h3F800003, 32'h3FC00000), {4'b0001, 32'h3FC00004});
      check("model_unf",     ref_mul(32'h00800000, 32'hBF7FFFFF), {4'b0011, 32'h80000000});
      check("model_ovf",     ref_mul(32'h7F000000, 32'h40000000), {4'b0101, 32'h7F800000});
      check("model_inv",     ref_mul(32'h7F800000, 32'h00000000), {4'b1000, 32'h7FC00000});
      check("model_subnorm", ref_mul(32'h00000001, 32'h7F000000), {4'b0000, 32'h00000000});

      send_one("basic",       32'h3FC00000, 32'h40000000, 5'd5,  32'h40400000);
      send_one("underflow",   32'h00800000, 32'hBF7FFFFF, 5'd1,  32'h80000000);
      send_one("overflow",    32'h7F000000, 32'h40000000, 5'd2,  32'h7F800000);
      send_one("inf_x_zero",  32'h7F800000, 32'h00000000, 5'd3,  32'h7FC00000);
      send_one("nan_in",      32'h7FC00000, 32'h3F800000, 5'd4,  32'h7FC00000);
      send_one("round_lsb",   32'h3F800001, 32'h3F800001, 5'd6,  32'h3F800002);
      send_one("round_big",   32'h3FFFFFFF, 32'h3FFFFFFF, 5'd7,  32'h407FFFFE);
      send_one("tie_up",      32'h3F800001, 32'h3FC00000, 5'd8,  32'h3FC00002);
      send_one("tie_even",    32'h3F800003, 32'h3FC00000, 5'd10, 32'h3FC00004);
      send_one("min_normal",  32'h00800000, 32'h3F800000, 5'd11, 32'h00800000);
      send_one("neg_inf",     32'hFF800000, 32'h3F800000, 5'd12, 32'hFF800000);
      send_one("neg_zero",    32'h00000000, 32'hBFC00000, 5'd31, 32'h80000000);

      run_stream(8, 1'b1);
      run_stream(300, 1'b0);
      reset_mid_flight();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
